// File: rtl/block_serializer.sv
// Drains 128-bit blocks from the block buffer and streams them out one byte at a
// time on a valid/ready interface toward the UART transmitter.
module block_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int BYTE_W    = 8,
    parameter int POP_WAIT  = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] i_fifo_dout,
    input  logic               i_fifo_empty,
    output logic               o_fifo_read_en,
    output logic [BYTE_W-1:0]  o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic [15:0]        o_blocks_sent
);

    localparam int NBYTES = BLOCK_W / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int HOLD_W = (POP_WAIT > 0) ? $clog2(POP_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(POP_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [BLOCK_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_byteCnt;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic [15:0]        r_blocksSent;

    logic               w_capture;
    logic               w_accept;
    logic               w_lastByte;
    logic [BYTE_W-1:0]  w_headByte;
    logic [BLOCK_W-1:0] w_shifted;

    assign w_capture  = (r_state == IDLE) && !i_fifo_empty && (r_holdCnt == '0);
    assign w_accept   = (r_state == SEND) && i_tx_ready;
    assign w_lastByte = (r_byteCnt == LAST_BYTE);

    // The outgoing byte always sits at the head of the shift register, so the
    // byte order is chosen purely by which end is presented and shifted away.
    generate
        if (MSB_FIRST != 0) begin : g_msbFirst
            assign w_headByte = r_shreg[BLOCK_W-1 -: BYTE_W];
            assign w_shifted  = r_shreg << BYTE_W;
        end else begin : g_lsbFirst
            assign w_headByte = r_shreg[BYTE_W-1:0];
            assign w_shifted  = r_shreg >> BYTE_W;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_nextState = POP;
                end
            end
            POP: begin
                w_nextState = SEND;
            end
            SEND: begin
                if (w_accept && w_lastByte) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Hold-off counts down in every state so a fresh head block is only
    // trusted once the buffer has had time to update its empty flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg      <= '0;
            r_byteCnt    <= '0;
            r_holdCnt    <= '0;
            r_blocksSent <= '0;
        end else begin
            if (r_state == POP) begin
                r_holdCnt <= HOLD_LOAD;
            end else if (r_holdCnt != '0) begin
                r_holdCnt <= r_holdCnt - HOLD_W'(1);
            end

            if (w_capture) begin
                r_shreg   <= i_fifo_dout;
                r_byteCnt <= '0;
            end else if (w_accept) begin
                r_shreg <= w_shifted;
                if (w_lastByte) begin
                    r_blocksSent <= r_blocksSent + 16'd1;
                end else begin
                    r_byteCnt <= r_byteCnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_fifo_read_en = (r_state == POP);
        o_tx_valid     = (r_state == SEND);
        o_tx_data      = w_headByte;
        o_busy         = (r_state != IDLE) || (r_holdCnt != '0);
        o_blocks_sent  = r_blocksSent;
    end

endmodule

// File: tb/tb_block_serializer.sv
// Directed bench for block_serializer: a default MSB-first instance fed by a small
// buffer model, an LSB-first instance, and a 2-byte instance that exposes hold-off.
module tb_block_serializer;

    localparam int POP_WAIT = 4;
    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] fifoDout;
    logic         fifoEmpty;
    logic         txReady;
    logic         readEn;
    logic [7:0]   txData;
    logic         txValid;
    logic         busy;
    logic [15:0]  blocksSent;

    logic         lsbEmpty;
    logic         lsbReadEn;
    logic [7:0]   lsbData;
    logic         lsbValid;
    logic         lsbBusy;
    logic [15:0]  lsbSent;

    logic [15:0]  smallDout;
    logic         smallEmpty;
    logic         smallReadEn;
    logic [7:0]   smallData;
    logic         smallValid;
    logic         smallBusy;
    logic [15:0]  smallSent;

    int errors = 0;
    int checks = 0;

    logic [127:0] blkQ[$];
    logic [7:0]   gotBytes[$];
    int           acceptCyc[$];
    int           popCyc[$];
    logic [8:0]   stallSamples[$];
    int           holdoff = 0;
    int           cyc = 0;
    logic         postResetValid;
    bit           resetDone;

    always #5 clk = ~clk;

    block_serializer #(.BLOCK_W(128), .BYTE_W(8), .POP_WAIT(POP_WAIT), .MSB_FIRST(1)) u_dut (
        .clk(clk), .reset(reset), .i_fifo_dout(fifoDout), .i_fifo_empty(fifoEmpty),
        .o_fifo_read_en(readEn), .o_tx_data(txData), .o_tx_valid(txValid),
        .i_tx_ready(txReady), .o_busy(busy), .o_blocks_sent(blocksSent)
    );

    block_serializer #(.BLOCK_W(128), .BYTE_W(8), .POP_WAIT(POP_WAIT), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .i_fifo_dout(fifoDout), .i_fifo_empty(lsbEmpty),
        .o_fifo_read_en(lsbReadEn), .o_tx_data(lsbData), .o_tx_valid(lsbValid),
        .i_tx_ready(txReady), .o_busy(lsbBusy), .o_blocks_sent(lsbSent)
    );

    block_serializer #(.BLOCK_W(16), .BYTE_W(8), .POP_WAIT(POP_WAIT), .MSB_FIRST(1)) u_small (
        .clk(clk), .reset(reset), .i_fifo_dout(smallDout), .i_fifo_empty(smallEmpty),
        .o_fifo_read_en(smallReadEn), .o_tx_data(smallData), .o_tx_valid(smallValid),
        .i_tx_ready(txReady), .o_busy(smallBusy), .o_blocks_sent(smallSent)
    );

    task automatic clearCollect();
        gotBytes.delete();
        acceptCyc.delete();
        popCyc.delete();
        stallSamples.delete();
        cyc = 0;
        resetDone = 1'b0;
        postResetValid = 1'bx;
    endtask

    // Buffer model plus TX sink: empty stays high POP_WAIT cycles after each pop.
    task automatic runCollect(input int nCycles, input int stallByte, input int stallLen,
                              input bit resetAfter8);
        int stallLeft;
        bit inReset;
        stallLeft = stallLen;
        inReset = 1'b0;
        for (int i = 0; i < nCycles; i++) begin
            @(negedge clk);
            cyc++;
            if (inReset) begin
                reset = 1'b1;
                inReset = 1'b0;
                postResetValid = txValid;
            end
            if (readEn) begin
                popCyc.push_back(cyc);
                if (blkQ.size() > 0) blkQ.delete(0);
                holdoff = POP_WAIT;
            end else if (holdoff > 0) begin
                holdoff--;
            end
            fifoEmpty = (blkQ.size() == 0) || (holdoff != 0);
            fifoDout = (blkQ.size() > 0) ? blkQ[0] : 128'h0;
            txReady = 1'b1;
            if (resetAfter8 && !resetDone && gotBytes.size() == 8) begin
                reset = 1'b0;
                txReady = 1'b0;
                inReset = 1'b1;
                resetDone = 1'b1;
            end else if (txValid && gotBytes.size() == stallByte && stallLeft > 0) begin
                txReady = 1'b0;
                stallLeft--;
                stallSamples.push_back({txValid, txData});
            end
            if (txValid && txReady) begin
                gotBytes.push_back(txData);
                acceptCyc.push_back(cyc);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        fifoEmpty = 1'b0;
        fifoDout = BLK_A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid cyc%0d got=%b exp=0", i, txValid); end
            checks++;
            if (readEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_en cyc%0d got=%b exp=0", i, readEn); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy cyc%0d got=%b exp=0", i, busy); end
            checks++;
            if (blocksSent !== 16'h0) begin errors++; $display("[TB] FAIL reset_blocks cyc%0d got=%h exp=0", i, blocksSent); end
            checks++;
            if (txData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data cyc%0d got=%h exp=00", i, txData); end
        end
        checks++;
        if ({lsbValid, lsbBusy, smallValid, smallBusy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_others got=%b exp=0000", {lsbValid, lsbBusy, smallValid, smallBusy});
        end
        fifoEmpty = 1'b1;
        fifoDout = 128'h0;
        reset = 1'b1;
    endtask

    task automatic test_single_block();
        clearCollect();
        blkQ.push_back(BLK_A);
        runCollect(30, -1, 0, 1'b0);
        checks++;
        if (popCyc.size() != 1) begin errors++; $display("[TB] FAIL single_pops got=%0d exp=1", popCyc.size()); end
        checks++;
        if (gotBytes.size() != 16) begin errors++; $display("[TB] FAIL single_count got=%0d exp=16", gotBytes.size()); end
        for (int k = 0; k < 16 && k < gotBytes.size(); k++) begin
            checks++;
            if (gotBytes[k] !== 8'(k * 17)) begin
                errors++;
                $display("[TB] FAIL single_byte%0d got=%h exp=%h", k, gotBytes[k], 8'(k * 17));
            end
        end
        if (popCyc.size() == 1 && acceptCyc.size() == 16) begin
            checks++;
            if (acceptCyc[0] != popCyc[0] + 1) begin
                errors++;
                $display("[TB] FAIL single_latency got=%0d exp=%0d", acceptCyc[0], popCyc[0] + 1);
            end
            checks++;
            if (acceptCyc[15] - acceptCyc[0] != 15) begin
                errors++;
                $display("[TB] FAIL single_consecutive got=%0d exp=15", acceptCyc[15] - acceptCyc[0]);
            end
        end
        checks++;
        if (blocksSent !== 16'd1) begin errors++; $display("[TB] FAIL single_blocks got=%0d exp=1", blocksSent); end
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle_after got valid=%b busy=%b exp 0 0", txValid, busy);
        end
    endtask

    task automatic test_backpressure();
        clearCollect();
        blkQ.push_back(BLK_A);
        runCollect(40, 3, 5, 1'b0);
        checks++;
        if (stallSamples.size() != 5) begin errors++; $display("[TB] FAIL stall_len got=%0d exp=5", stallSamples.size()); end
        foreach (stallSamples[i]) begin
            checks++;
            if (stallSamples[i] !== 9'h133) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got=%h exp=133", i, stallSamples[i]);
            end
        end
        checks++;
        if (gotBytes.size() != 16) begin errors++; $display("[TB] FAIL stall_count got=%0d exp=16", gotBytes.size()); end
        for (int k = 0; k < 16 && k < gotBytes.size(); k++) begin
            checks++;
            if (gotBytes[k] !== 8'(k * 17)) begin
                errors++;
                $display("[TB] FAIL stall_byte%0d got=%h exp=%h", k, gotBytes[k], 8'(k * 17));
            end
        end
        if (acceptCyc.size() == 16) begin
            checks++;
            if (acceptCyc[15] - acceptCyc[0] != 20) begin
                errors++;
                $display("[TB] FAIL stall_span got=%0d exp=20", acceptCyc[15] - acceptCyc[0]);
            end
        end
        checks++;
        if (blocksSent !== 16'd2) begin errors++; $display("[TB] FAIL stall_blocks got=%0d exp=2", blocksSent); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk;
        logic [7:0]   expByte;
        clearCollect();
        blkQ.push_back(BLK_A);
        blkQ.push_back(BLK_B);
        runCollect(60, -1, 0, 1'b0);
        checks++;
        if (popCyc.size() != 2) begin errors++; $display("[TB] FAIL b2b_pops got=%0d exp=2", popCyc.size()); end
        if (popCyc.size() == 2) begin
            checks++;
            if (popCyc[1] - popCyc[0] < POP_WAIT + 1) begin
                errors++;
                $display("[TB] FAIL b2b_pop_gap got=%0d exp>=%0d", popCyc[1] - popCyc[0], POP_WAIT + 1);
            end
        end
        checks++;
        if (gotBytes.size() != 32) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=32", gotBytes.size()); end
        for (int k = 0; k < 32 && k < gotBytes.size(); k++) begin
            blk = (k < 16) ? BLK_A : BLK_B;
            expByte = blk[8 * (15 - (k % 16)) +: 8];
            checks++;
            if (gotBytes[k] !== expByte) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d got=%h exp=%h", k, gotBytes[k], expByte);
            end
        end
        checks++;
        if (blocksSent !== 16'd4) begin errors++; $display("[TB] FAIL b2b_blocks got=%0d exp=4", blocksSent); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] lsbBytes[$];
        int         lsbPops;
        lsbPops = 0;
        fifoDout = BLK_A;
        @(negedge clk);
        lsbEmpty = 1'b0;
        txReady = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lsbReadEn) begin
                lsbPops++;
                lsbEmpty = 1'b1;
            end
            if (lsbValid && txReady) lsbBytes.push_back(lsbData);
        end
        checks++;
        if (lsbPops != 1) begin errors++; $display("[TB] FAIL lsb_pops got=%0d exp=1", lsbPops); end
        checks++;
        if (lsbBytes.size() != 16) begin errors++; $display("[TB] FAIL lsb_count got=%0d exp=16", lsbBytes.size()); end
        for (int k = 0; k < 16 && k < lsbBytes.size(); k++) begin
            checks++;
            if (lsbBytes[k] !== 8'(255 - k * 17)) begin
                errors++;
                $display("[TB] FAIL lsb_byte%0d got=%h exp=%h", k, lsbBytes[k], 8'(255 - k * 17));
            end
        end
        checks++;
        if (lsbSent !== 16'd1) begin errors++; $display("[TB] FAIL lsb_blocks got=%0d exp=1", lsbSent); end
        fifoDout = 128'h0;
    endtask

    // Two-byte blocks finish before the hold-off expires, so the gap is visible.
    task automatic test_holdoff();
        int         pops[$];
        logic [7:0] bytesSeen[$];
        logic       busyLog[13];
        int         busyLow;
        smallDout = 16'hA55A;
        txReady = 1'b1;
        @(negedge clk);
        smallEmpty = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (smallReadEn) pops.push_back(c);
            busyLog[c] = smallBusy;
            if (smallValid && txReady) bytesSeen.push_back(smallData);
        end
        smallEmpty = 1'b1;
        checks++;
        if (pops.size() != 2) begin errors++; $display("[TB] FAIL hold_pops got=%0d exp=2", pops.size()); end
        if (pops.size() >= 2) begin
            checks++;
            if (pops[1] - pops[0] != 6) begin
                errors++;
                $display("[TB] FAIL hold_gap got=%0d exp=6", pops[1] - pops[0]);
            end
            busyLow = 0;
            for (int c = pops[0] + 1; c < pops[1]; c++) if (busyLog[c] === 1'b0) busyLow++;
            checks++;
            if (busyLow != 1) begin errors++; $display("[TB] FAIL hold_busy_low got=%0d exp=1", busyLow); end
        end
        checks++;
        if (bytesSeen.size() < 2 || bytesSeen[0] !== 8'hA5 || bytesSeen[1] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL hold_bytes got=%0d bytes first=%h exp A5 5A", bytesSeen.size(),
                     (bytesSeen.size() > 0) ? bytesSeen[0] : 8'hxx);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_block();
        clearCollect();
        blkQ.push_back(BLK_A);
        runCollect(40, -1, 0, 1'b1);
        checks++;
        if (!resetDone) begin errors++; $display("[TB] FAIL midrst_issued got=0 exp=1"); end
        checks++;
        if (postResetValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b exp=0", postResetValid); end
        checks++;
        if (gotBytes.size() != 8) begin errors++; $display("[TB] FAIL midrst_count got=%0d exp=8", gotBytes.size()); end
        if (gotBytes.size() >= 8) begin
            checks++;
            if (gotBytes[7] !== 8'h77) begin errors++; $display("[TB] FAIL midrst_byte7 got=%h exp=77", gotBytes[7]); end
        end
        checks++;
        if (popCyc.size() != 1) begin errors++; $display("[TB] FAIL midrst_pops got=%0d exp=1", popCyc.size()); end
        checks++;
        if (blocksSent !== 16'd0) begin errors++; $display("[TB] FAIL midrst_blocks got=%0d exp=0", blocksSent); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    endtask

    initial begin
        reset = 1'b0;
        fifoDout = 128'h0;
        fifoEmpty = 1'b1;
        lsbEmpty = 1'b1;
        smallDout = 16'h0;
        smallEmpty = 1'b1;
        txReady = 1'b0;
        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_lsb_first();
        test_holdoff();
        test_reset_mid_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
